// File: rtl/img_pkg.sv
// Shared image-path types: pixel and coordinate widths, plus the Bayer phase enumeration.
package img_pkg;
  localparam int PIX_W  = 12;
  localparam int LINE_W = 1280;
  localparam int X_W    = 11;
  localparam int Y_W    = 11;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [X_W-1:0]   xcoord_t;
  typedef logic [Y_W-1:0]   ycoord_t;

  typedef enum logic [1:0] {
    GR = 2'd0,
    R  = 2'd1,
    B  = 2'd2,
    GB = 2'd3
  } bayer_phase_t;

  // Phase of a pixel from the parity of its row and column.
  function automatic bayer_phase_t phase_of(input logic y_lsb, input logic x_lsb);
    return bayer_phase_t'({y_lsb, x_lsb});
  endfunction
endpackage

// File: rtl/line_ram.sv
// One-line pixel store: simple dual-port synchronous RAM, registered read, old data on collision.
module line_ram #(
  parameter int DEPTH = img_pkg::LINE_W,
  parameter int WIDTH = img_pkg::PIX_W,
  parameter int AW    = img_pkg::X_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  import img_pkg::*;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; same-edge write is not yet visible, giving read-old-data.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;
endmodule

// File: rtl/bayer_line_tap.sv
// Vertical tap generator: emits each pixel with the same-column pixel of the previous line,
// plus column, row and Bayer phase, one cycle after acceptance.
module bayer_line_tap #(
  parameter int PIX_W  = img_pkg::PIX_W,
  parameter int LINE_W = img_pkg::LINE_W,
  parameter int X_W    = img_pkg::X_W,
  parameter int Y_W    = img_pkg::Y_W
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic [PIX_W-1:0] iDATA,
  output logic [PIX_W-1:0] oTAP0,
  output logic [PIX_W-1:0] oTAP1,
  output logic             oDVAL,
  output logic [X_W-1:0]   oX,
  output logic [Y_W-1:0]   oY,
  output logic [1:0]       oPHASE
);
  import img_pkg::*;

  logic [1:0]       rst_sync_r;
  logic             rst_n_s;
  logic             accept_s;
  logic [X_W-1:0]   col_r;
  logic [Y_W-1:0]   row_r;
  logic [PIX_W-1:0] tap0_r;
  logic [PIX_W-1:0] ram_rd_s;
  logic             dval_r;
  logic [X_W-1:0]   x_r;
  logic [Y_W-1:0]   y_r;
  bayer_phase_t     phase_r;

  // Reset synchroniser: asynchronous assertion, two-flop synchronised release.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s  = rst_sync_r[1];
  assign accept_s = iFVAL & iDVAL;

  line_ram #(
    .DEPTH(LINE_W),
    .WIDTH(PIX_W),
    .AW   (X_W)
  ) u_line_ram (
    .clk  (iCLK),
    .we   (accept_s),
    .waddr(col_r),
    .wdata(iDATA),
    .re   (accept_s),
    .raddr(col_r),
    .rdata(ram_rd_s)
  );

  // Position counters and the output pipeline register; outputs hold on non-accept cycles.
  always_ff @(posedge iCLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      col_r   <= {X_W{1'b0}};
      row_r   <= {Y_W{1'b0}};
      tap0_r  <= {PIX_W{1'b0}};
      dval_r  <= 1'b0;
      x_r     <= {X_W{1'b0}};
      y_r     <= {Y_W{1'b0}};
      phase_r <= GR;
    end else if (!iFVAL) begin
      col_r  <= {X_W{1'b0}};
      row_r  <= {Y_W{1'b0}};
      dval_r <= 1'b0;
    end else if (iDVAL) begin
      tap0_r  <= iDATA;
      dval_r  <= 1'b1;
      x_r     <= col_r;
      y_r     <= row_r;
      phase_r <= phase_of(row_r[0], col_r[0]);
      if (col_r == X_W'(LINE_W - 1)) begin
        col_r <= {X_W{1'b0}};
        row_r <= row_r + {{(Y_W-1){1'b0}}, 1'b1};
      end else begin
        col_r <= col_r + {{(X_W-1){1'b0}}, 1'b1};
      end
    end else begin
      dval_r <= 1'b0;
    end
  end

  // Row 0 masks the RAM output so stale lines from earlier frames never leak out.
  assign oTAP1  = (y_r == {Y_W{1'b0}}) ? {PIX_W{1'b0}} : ram_rd_s;
  assign oTAP0  = tap0_r;
  assign oDVAL  = dval_r;
  assign oX     = x_r;
  assign oY     = y_r;
  assign oPHASE = phase_r;
endmodule
